frac_le: RTL and testbench
==========================

FRAC_LE -- requirements
Module: frac_le

Interface
REQ-001 SHALL have parameter K, default 4, LUT input count (K >= 2).
REQ-002 SHALL derive localparam CFG_W = 2**K + 7, the config frame width.
REQ-003 SHALL have port clk, input, 1, config clock.
REQ-004 SHALL have port nrst, input, 1, config reset; asynchronous, active-low.
REQ-005 SHALL have ports le_clk / le_nrst / le_en / le_srst, input, 1 each: user clock, async active-low user reset, user FF enable, user sync reset.
REQ-006 SHALL have port lut_in, input, K, LUT select lines.
REQ-007 SHALL have ports cin (input, 1) and cout (output, 1): carry chain.
REQ-008 SHALL have ports cfg_in, cfg_en, cfg_commit (input, 1 each) and cfg_out (output, 1): serial config chain.
REQ-009 SHALL have outputs cfg_valid, cfg_err, out0, out1, 1 bit each.

Function
REQ-010 SHALL hold a CFG_W-bit shadow register and a separate CFG_W-bit active register (double-buffered).
REQ-011 On clk edge with cfg_en=1: shadow <= {shadow[CFG_W-2:0], cfg_in}; cfg_out = shadow[CFG_W-1], combinational.
REQ-012 Active layout, LSB first: [2**K-1:0] LUT, then ff0_en, ff1_en, frac, carry_en, init0, init1, srst_en (MSB).
REQ-013 Loader FSM SHALL have states L_IDLE, L_SHIFT, L_FULL, plus a bit counter saturating at CFG_W.
REQ-014 L_IDLE->L_SHIFT on first cfg_en; L_SHIFT->L_FULL when the counter reaches CFG_W; L_FULL persists through further shifts.
REQ-015 cfg_commit=1 with cfg_en=0 in L_FULL: active <= shadow and cfg_valid <= 1 on that edge; counter cleared; FSM -> L_IDLE; cfg_err cleared.
REQ-016 cfg_commit in L_IDLE/L_SHIFT SHALL set cfg_err=1 with active, cfg_valid and the FSM unchanged.
REQ-017 cfg_commit together with cfg_en SHALL perform the shift only and set cfg_err=1.
REQ-018 Shifting SHALL NOT disturb the active configuration; outputs follow the old function until the commit edge.
REQ-019 Non-frac mode: f0 = LUT[lut_in]; f1 = 0.
REQ-020 Frac mode: f0 = LUT[lut_in[K-2:0]], f1 = LUT[2**(K-1) + lut_in[K-2:0]]; lut_in[K-1] ignored.
REQ-021 carry_en=1 (valid only with frac=1): comb0 = f0 ^ cin; cout = f0 ? cin : f1. With carry_en=0: comb0 = f0, cout = 0.
REQ-022 comb1 = f1.
REQ-023 User FF n (n=0,1): on le_clk, le_srst=1 with srst_en=1 loads initn; else le_en=1 loads combn; else holds.
REQ-024 outn = ffn_en ? FF n : combn, combinational from lut_in/cin (zero latency).
REQ-025 cfg_valid=0 SHALL force out0, out1 and cout to 0; no tri-state outputs.

Reset
REQ-026 nrst low SHALL clear shadow, active, counter, cfg_err and cfg_valid, and return the FSM to L_IDLE; outputs 0.
REQ-027 le_nrst low SHALL asynchronously set FF0 to init0 and FF1 to init1 from the active register.
REQ-028 nrst mid-shift or mid-commit SHALL discard all partial data.

Structure
REQ-029 Package svfpga_pkg SHALL hold the loader state enum and the mode-bit index constants.
REQ-030 Sub-module frac_le_cfg SHALL contain the shadow/active registers, counter and loader FSM; the LUT/carry/FF datapath stays in frac_le.

Verification (K=4, CFG_W=23)
REQ-031 Shift 23 bits (LUT=16'h8000, mode bits 0), commit -> cfg_valid=1; lut_in=4'hF gives out0=1, lut_in=4'hE gives out0=0.
REQ-032 Commit after 10 shifted bits -> cfg_err=1, cfg_valid=0, out0=0.
REQ-033 Running AND, shift XOR frame (LUT=16'h6996) -> out0 stays AND until the commit edge, then XOR (lut_in=4'h1 gives out0=1).
REQ-034 frac=1, carry_en=1, lower LUT=XOR(in1,in0), upper LUT=AND; lut_in=2'b01, cin=1 -> out0=0, cout=1; lut_in=2'b11, cin=0 -> out0=0, cout=1.
REQ-035 ff0_en=1, init0=1, srst_en=1: le_nrst pulse -> out0=1; le_en=1, comb0=0 -> out0=0 after one le_clk edge; le_srst=1 -> out0=1.
REQ-036 nrst asserted after 12 shifted bits -> cfg_valid=0 and the counter at 0; then a 23-bit frame and commit succeed.

Source files
------------

// File: rtl/svfpga_pkg.sv
// rtl/svfpga_pkg.sv - shared loader state and mode-bit layout for the fracturable logic element
// Purpose : types and constants shared by frac_le and frac_le_cfg.
// Contents: load_state_t loader states; MB_* offsets of the mode bits above the LUT field.
package svfpga_pkg;

   typedef enum logic [1:0] {
      L_IDLE  = 2'd0,
      L_SHIFT = 2'd1,
      L_FULL  = 2'd2
   } load_state_t;

   // Mode bits sit directly above the 2**K LUT bits in the config frame.
   localparam int MB_FF0_EN   = 0;
   localparam int MB_FF1_EN   = 1;
   localparam int MB_FRAC     = 2;
   localparam int MB_CARRY_EN = 3;
   localparam int MB_INIT0    = 4;
   localparam int MB_INIT1    = 5;
   localparam int MB_SRST_EN  = 6;
   localparam int MODE_W      = 7;

endpackage

// File: rtl/frac_le_if.sv
// rtl/frac_le_if.sv - serial configuration chain interface of the logic element
// Purpose : bundles the config shift/commit handshake and its status.
// Signals : cfg_in, cfg_en, cfg_commit (master -> element); cfg_out, cfg_valid, cfg_err (element -> master).
interface frac_le_if;
   logic cfg_in;
   logic cfg_en;
   logic cfg_commit;
   logic cfg_out;
   logic cfg_valid;
   logic cfg_err;

   modport master (output cfg_in, cfg_en, cfg_commit, input cfg_out, cfg_valid, cfg_err);
   modport slave  (input cfg_in, cfg_en, cfg_commit, output cfg_out, cfg_valid, cfg_err);
endinterface

// File: rtl/frac_le_cfg.sv
// rtl/frac_le_cfg.sv - double-buffered config loader (shadow chain, active frame, loader FSM)
// Purpose : shifts a frame into the shadow register and copies it to the active
//           register on a legal commit, so the running function never sees partial data.
// Ports   : clk, nrst (async active-low) - config clock/reset
//           cfg (slave)                   - serial chain and status
//           active_o                      - committed frame, LUT in the low 2**K bits
module frac_le_cfg
   import svfpga_pkg::*;
#(
   parameter int K = 4
) (
   input  logic                     clk,
   input  logic                     nrst,
   frac_le_if.slave                 cfg,
   output logic [2**K+MODE_W-1:0]   active_o
);

   localparam int CFG_W = 2**K + MODE_W;
   localparam int CNT_W = $clog2(CFG_W + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);

   logic [CFG_W-1:0] shadow_q;
   logic [CFG_W-1:0] active_q;
   logic [CNT_W-1:0] cnt_q;
   load_state_t      state_q;
   logic             valid_q;
   logic             err_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         shadow_q <= '0;
         active_q <= '0;
         cnt_q    <= '0;
         state_q  <= L_IDLE;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else if (cfg.cfg_en) begin
         // A commit that collides with a shift is rejected; the shift still happens.
         shadow_q <= {shadow_q[CFG_W-2:0], cfg.cfg_in};
         if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
         case (state_q)
            L_IDLE:  state_q <= L_SHIFT;
            L_SHIFT: if (cnt_q == CNT_MAX - CNT_W'(1)) state_q <= L_FULL;
            default: ;
         endcase
         if (cfg.cfg_commit) err_q <= 1'b1;
      end else if (cfg.cfg_commit) begin
         if (state_q == L_FULL) begin
            active_q <= shadow_q;
            valid_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= L_IDLE;
            err_q    <= 1'b0;
         end else begin
            err_q    <= 1'b1;
         end
      end
   end

   assign cfg.cfg_out   = shadow_q[CFG_W-1];
   assign cfg.cfg_valid = valid_q;
   assign cfg.cfg_err   = err_q;
   assign active_o      = active_q;

endmodule

// File: rtl/frac_le.sv
// rtl/frac_le.sv - fracturable K-input LUT logic element with carry and two user FFs
// Purpose : evaluates a K-LUT (or two (K-1)-LUTs in frac mode) with optional carry,
//           optionally registering each result in a user flip-flop.
// Ports   : clk, nrst                   - config clock / async active-low config reset
//           le_clk, le_nrst             - user clock / async active-low user reset
//           le_en, le_srst              - user FF enable / user sync reset
//           lut_in, cin, cout           - LUT select lines and carry chain
//           cfg (slave)                 - serial config chain
//           out0, out1                  - element outputs (0 until a frame is committed)
module frac_le
   import svfpga_pkg::*;
#(
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         le_clk,
   input  logic         le_nrst,
   input  logic         le_en,
   input  logic         le_srst,
   input  logic [K-1:0] lut_in,
   input  logic         cin,
   output logic         cout,
   frac_le_if.slave     cfg,
   output logic         out0,
   output logic         out1
);

   localparam int LUT_N = 2**K;
   localparam int CFG_W = 2**K + 7;

   logic [CFG_W-1:0] active;
   logic [LUT_N-1:0] lut;
   logic ff0_en, ff1_en, frac, carry_en, init0, init1, srst_en;
   logic f0, f1, comb0, comb1, cout_raw;
   logic ff0_q, ff1_q;

   frac_le_cfg #(.K(K)) u_cfg (
      .clk      (clk),
      .nrst     (nrst),
      .cfg      (cfg),
      .active_o (active)
   );

   assign lut      = active[LUT_N-1:0];
   assign ff0_en   = active[LUT_N + MB_FF0_EN];
   assign ff1_en   = active[LUT_N + MB_FF1_EN];
   assign frac     = active[LUT_N + MB_FRAC];
   assign carry_en = active[LUT_N + MB_CARRY_EN];
   assign init0    = active[LUT_N + MB_INIT0];
   assign init1    = active[LUT_N + MB_INIT1];
   assign srst_en  = active[LUT_N + MB_SRST_EN];

   // Frac mode splits the table in halves addressed by the low K-1 inputs.
   always_comb begin
      f0       = 1'b0;
      f1       = 1'b0;
      comb0    = 1'b0;
      cout_raw = 1'b0;
      if (frac) begin
         f0 = lut[{1'b0, lut_in[K-2:0]}];
         f1 = lut[{1'b1, lut_in[K-2:0]}];
      end else begin
         f0 = lut[lut_in];
      end
      comb0 = f0;
      if (carry_en) begin
         // f0 acts as propagate, f1 as generate.
         comb0    = f0 ^ cin;
         cout_raw = f0 ? cin : f1;
      end
   end

   assign comb1 = f1;

   // Async reset value comes from the committed frame, not a constant.
   always_ff @(posedge le_clk or negedge le_nrst) begin
      if (!le_nrst) begin
         ff0_q <= init0;
         ff1_q <= init1;
      end else begin
         if (le_srst && srst_en) ff0_q <= init0;
         else if (le_en)         ff0_q <= comb0;
         if (le_srst && srst_en) ff1_q <= init1;
         else if (le_en)         ff1_q <= comb1;
      end
   end

   assign out0 = cfg.cfg_valid & (ff0_en ? ff0_q : comb0);
   assign out1 = cfg.cfg_valid & (ff1_en ? ff1_q : comb1);
   assign cout = cfg.cfg_valid & cout_raw;

endmodule

// File: tb/tb_frac_le.sv
// tb/tb_frac_le.sv - self-checking bench for frac_le against a behavioural model
module tb_frac_le;

   localparam int K     = 4;
   localparam int CFG_W = 23;

   logic clk = 1'b0, nrst = 1'b0;
   logic le_clk = 1'b0, le_nrst = 1'b0, le_en = 1'b0, le_srst = 1'b0;
   logic [K-1:0] lut_in = '0;
   logic cin = 1'b0;
   logic cout, out0, out1;

   frac_le_if cfg_if();

   frac_le #(.K(K)) dut (
      .clk     (clk),
      .nrst    (nrst),
      .le_clk  (le_clk),
      .le_nrst (le_nrst),
      .le_en   (le_en),
      .le_srst (le_srst),
      .lut_in  (lut_in),
      .cin     (cin),
      .cout    (cout),
      .cfg     (cfg_if),
      .out0    (out0),
      .out1    (out1)
   );

   always #5 clk = ~clk;

   logic [CFG_W-1:0] m_shadow = '0, m_active = '0;
   int  m_cnt = 0;
   bit  m_valid = 0, m_err = 0, m_ff0 = 0, m_ff1 = 0;
   int  errors = 0, checks = 0;
   bit  run = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Returns {cout_raw, comb1, comb0} from the committed frame and current inputs.
   function automatic logic [2:0] m_comb();
      logic [15:0] lut;
      logic [6:0]  md;
      int f0, f1, c0, co;
      lut = m_active[15:0];
      md  = m_active[22:16];
      if (md[2]) begin
         f0 = int'((lut >> lut_in[2:0]) & 16'd1);
         f1 = int'((lut >> (8 + int'(lut_in[2:0]))) & 16'd1);
      end else begin
         f0 = int'((lut >> lut_in) & 16'd1);
         f1 = 0;
      end
      c0 = md[3] ? (f0 ^ int'(cin)) : f0;
      co = md[3] ? (f0 != 0 ? int'(cin) : f1) : 0;
      return {co[0], f1[0], c0[0]};
   endfunction

   // Returns {cout, out1, out0} as seen at the pins.
   function automatic logic [2:0] m_out();
      logic [2:0] c;
      logic o0, o1;
      c  = m_comb();
      o0 = m_active[16] ? m_ff0 : c[0];
      o1 = m_active[17] ? m_ff1 : c[1];
      return {m_valid & c[2], m_valid & o1, m_valid & o0};
   endfunction

   always @(negedge clk) begin
      if (run) begin
         logic [2:0] e;
         e = m_out();
         check("cfg_valid", cfg_if.cfg_valid, m_valid);
         check("cfg_err",   cfg_if.cfg_err,   m_err);
         check("cfg_out",   cfg_if.cfg_out,   m_shadow[CFG_W-1]);
         check("out0",      out0, e[0]);
         check("out1",      out1, e[1]);
         check("cout",      cout, e[2]);
      end
   end

   task automatic cyc(input logic en, input logic com, input logic din);
      cfg_if.cfg_en     = en;
      cfg_if.cfg_commit = com;
      cfg_if.cfg_in     = din;
      @(posedge clk);
      if (en) begin
         m_shadow = {m_shadow[CFG_W-2:0], din};
         if (m_cnt < CFG_W) m_cnt++;
         if (com) m_err = 1;
      end else if (com) begin
         if (m_cnt == CFG_W) begin
            m_active = m_shadow;
            m_valid  = 1;
            m_cnt    = 0;
            m_err    = 0;
         end else begin
            m_err = 1;
         end
      end
      #1;
      cfg_if.cfg_en     = 1'b0;
      cfg_if.cfg_commit = 1'b0;
   endtask

   task automatic shift_frame(input logic [CFG_W-1:0] f);
      for (int i = CFG_W - 1; i >= 0; i--) cyc(1'b1, 1'b0, f[i]);
   endtask

   task automatic nrst_pulse();
      nrst = 1'b0;
      m_shadow = '0; m_active = '0; m_cnt = 0; m_valid = 0; m_err = 0;
      #1 nrst = 1'b1;
      #1;
   endtask

   task automatic le_nrst_pulse();
      le_nrst = 1'b0;
      m_ff0 = m_active[20];
      m_ff1 = m_active[21];
      #1 le_nrst = 1'b1;
      #1;
   endtask

   task automatic le_tick();
      logic [2:0] c;
      c = m_comb();
      le_clk = 1'b1;
      if (le_srst && m_active[22]) begin
         m_ff0 = m_active[20];
         m_ff1 = m_active[21];
      end else if (le_en) begin
         m_ff0 = c[0];
         m_ff1 = c[1];
      end
      #1 le_clk = 1'b0;
      #1;
   endtask

   function automatic logic [CFG_W-1:0] frame(input logic [6:0] md, input logic [15:0] lut);
      return {md, lut};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] e;
      cfg_if.cfg_in = 1'b0; cfg_if.cfg_en = 1'b0; cfg_if.cfg_commit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1; le_nrst = 1'b1;
      run = 1;

      // Reset state
      cyc(0, 0, 0);
      check("rst_valid", cfg_if.cfg_valid, 0);
      check("rst_err",   cfg_if.cfg_err, 0);
      check("rst_out0",  out0, 0);
      check("rst_cout",  cout, 0);
      check("rst_cnt",   dut.u_cfg.cnt_q, 0);

      // Early commit after 10 bits
      repeat (10) cyc(1, 0, 1'b1);
      cyc(0, 1, 0);
      check("early_err",   cfg_if.cfg_err, 1);
      check("early_valid", cfg_if.cfg_valid, 0);
      check("early_out0",  out0, 0);

      // AND4 frame
      shift_frame(frame(7'b0, 16'h8000));
      cyc(0, 1, 0);
      check("and_valid", cfg_if.cfg_valid, 1);
      check("and_err",   cfg_if.cfg_err, 0);
      lut_in = 4'hF; cyc(0, 0, 0);
      check("and_F", out0, 1);
      e = m_out();
      check("model_and_F", e[0], 1);
      lut_in = 4'hE; cyc(0, 0, 0);
      check("and_E", out0, 0);

      // Shift XOR frame while AND runs
      for (int i = CFG_W - 1; i >= 12; i--) cyc(1, 0, frame(7'b0, 16'h6996) >> i);
      lut_in = 4'hF; cyc(0, 0, 0);
      check("mid_and_F", out0, 1);
      for (int i = 11; i >= 0; i--) cyc(1, 0, frame(7'b0, 16'h6996) >> i);
      lut_in = 4'h1; cyc(0, 0, 0);
      check("pre_commit_1", out0, 0);
      cyc(0, 1, 0);
      check("xor_1", out0, 1);
      e = m_out();
      check("model_xor_1", e[0], 1);

      // Frac + carry: lower XOR(in1,in0), upper AND(in1,in0)
      shift_frame(frame(7'b0001100, 16'h8866));
      cyc(0, 1, 0);
      lut_in = 4'b0001; cin = 1'b1; cyc(0, 0, 0);
      check("carry_a_out0", out0, 0);
      check("carry_a_cout", cout, 1);
      e = m_out();
      check("model_carry_a", {e[2], e[0]}, 2'b10);
      lut_in = 4'b0011; cin = 1'b0; cyc(0, 0, 0);
      check("carry_b_out0", out0, 0);
      check("carry_b_cout", cout, 1);
      check("carry_b_out1", out1, 1);
      lut_in = 4'b1011; cyc(0, 0, 0);
      check("carry_msb_ignored", cout, 1);

      // Registered output with init and sync reset
      shift_frame(frame(7'b1010001, 16'h0000));
      cyc(0, 1, 0);
      le_nrst_pulse();
      cyc(0, 0, 0);
      check("ff_le_nrst", out0, 1);
      le_en = 1'b1; le_tick();
      cyc(0, 0, 0);
      check("ff_load0", out0, 0);
      le_srst = 1'b1; le_tick();
      cyc(0, 0, 0);
      check("ff_srst", out0, 1);
      le_en = 1'b0; le_srst = 1'b0;

      // Config reset mid-shift
      repeat (12) cyc(1, 0, 1'b1);
      nrst_pulse();
      cyc(0, 0, 0);
      check("nrst_valid", cfg_if.cfg_valid, 0);
      check("nrst_cnt",   dut.u_cfg.cnt_q, 0);
      check("nrst_out0",  out0, 0);
      shift_frame(frame(7'b0, 16'h8000));
      cyc(0, 1, 0);
      check("post_nrst_valid", cfg_if.cfg_valid, 1);
      check("post_nrst_err",   cfg_if.cfg_err, 0);

      // Randomized rounds
      for (int r = 0; r < 40; r++) begin
         int n;
         n = $urandom_range(8, 27);
         for (int i = 0; i < n; i++) begin
            lut_in = K'($urandom);
            cin    = 1'($urandom);
            cyc(1, ($urandom_range(0, 9) == 0), 1'($urandom));
         end
         if ($urandom_range(0, 5) == 0) nrst_pulse();
         cyc(0, 1, 0);
         repeat (4) begin
            lut_in  = K'($urandom);
            cin     = 1'($urandom);
            le_en   = 1'($urandom);
            le_srst = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) le_nrst_pulse();
            else le_tick();
            cyc(0, 0, 0);
         end
         le_en = 1'b0; le_srst = 1'b0;
      end

      run = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
